mac_result_accumulator: RTL



---
 rtl/mac_result_accumulator_pkg.sv | 22 ++
 rtl/mac_result_accumulator_sat_add.sv | 25 ++
 rtl/mac_result_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mac_result_accumulator_pkg.sv
// ============================================================================
// Module      : registr_parameter (package)
// Description : Shared widths and state encoding for the MAC result accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package registr_parameter;

    localparam int size  = 8;
    localparam int GUARD = 4;
    localparam int ACC_W = 2*size + 1 + GUARD;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_result_accumulator_sat_add.sv
// ============================================================================
// Module      : sat_add
// Description : Unsigned adder that clamps at all-ones and flags the overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o  = w_full[W];
    assign sum_o  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

`default_nettype wire

// File: rtl/mac_result_accumulator.sv
// ============================================================================
// Module      : mac_result_accumulator
// Description : Sums framed multiply-add results; presents sum/count/sat on a
//               valid/ready handshake and flags terms lost to backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_accumulator #(
    parameter  int SIZE  = registr_parameter::size,
    parameter  int GUARD = registr_parameter::GUARD,
    localparam int ACC_W = 2*SIZE + 1 + GUARD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*SIZE:0]   in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [GUARD:0]    out_count,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_err
);

    import registr_parameter::*;

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [GUARD:0]   cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [GUARD:0]   out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;
    logic             drop_q, drop_d;

    logic             w_accept;
    logic [ACC_W-1:0] w_in_ext;
    logic [ACC_W-1:0] w_base_acc;
    logic [GUARD:0]   w_base_cnt;
    logic             w_base_sat;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic [GUARD:0]   w_cnt_inc;
    logic             w_sat_new;

    assign in_ready  = (state_q != DONE) | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_in_ext  = {{GUARD{1'b0}}, in_data};

    // Any accepted term outside ACCUM opens a fresh frame, so it adds onto zero.
    assign w_base_acc = (state_q == ACCUM) ? acc_q : '0;
    assign w_base_cnt = (state_q == ACCUM) ? cnt_q : '0;
    assign w_base_sat = (state_q == ACCUM) ? sat_q : 1'b0;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a_i   (w_base_acc),
        .b_i   (w_in_ext),
        .sum_o (w_sum),
        .ovf_o (w_ovf)
    );

    assign w_cnt_inc = (w_base_cnt == {(GUARD+1){1'b1}}) ? w_base_cnt
                                                         : w_base_cnt + (GUARD+1)'(1);
    assign w_sat_new = w_base_sat | w_ovf;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        drop_d      = in_valid & ~in_ready;

        if (w_accept) begin
            if (in_last) begin
                out_data_d  = w_sum;
                out_count_d = w_cnt_inc;
                out_sat_d   = w_sat_new;
                acc_d       = '0;
                cnt_d       = '0;
                sat_d       = 1'b0;
                state_d     = DONE;
            end else begin
                acc_d   = w_sum;
                cnt_d   = w_cnt_inc;
                sat_d   = w_sat_new;
                state_d = ACCUM;
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            drop_q      <= drop_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;
    assign out_valid = (state_q == DONE);
    assign drop_err  = drop_q;

endmodule

`default_nettype wire
